// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority helper for the round-robin req/gnt arbiter family.
// Requester vectors are widened to ArbMaxReqs bits so one helper serves every arbiter width.
package arb_pkg;

    localparam int unsigned ArbMaxReqs = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // First set bit of req at or after ptr, wrapping modulo 16. Zero-padded upper bits are
    // never set, so the 16-way wrap behaves like a wrap at the caller's real width.
    function automatic logic [3:0] rr_next(input logic [ArbMaxReqs-1:0] req,
                                           input logic [3:0]            ptr);
        logic [3:0] idx;
        logic [3:0] pos;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(ArbMaxReqs); k++) begin
            pos = ptr + 4'(k);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first requester at or after ptr, circularly.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] ptr,
    output logic [IdW-1:0] idx,
    output logic           found
);

    assign found = |req;
    assign idx   = IdW'(rr_next(ArbMaxReqs'(req), 4'(ptr)));

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with a MAX_HOLD tenure limit and forced preemption.
// Define RR_ARB_SVA_EN to compile in the protocol assertions and per-requester covers.
module rr_req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 preempt
);

    localparam int unsigned IdW   = $clog2(N);
    localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IdW-1:0]   owner_q, owner_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic             owner_req;
    logic             expired;
    logic             tenure_end;
    logic [IdW-1:0]   next_ptr;
    logic [IdW-1:0]   pick_ptr;
    logic [IdW-1:0]   pick_idx;
    logic             pick_found;

    assign owner_req  = req[owner_q];
    assign expired    = (MAX_HOLD != 0) && (hold_q == HoldW'(MAX_HOLD));
    assign tenure_end = !owner_req || expired;
    assign next_ptr   = (owner_q == IdW'(N - 1)) ? '0 : owner_q + IdW'(1);

    // During a tenure the search starts just past the owner, so a still-requesting
    // preempted owner is considered last; in IDLE the stored pointer already holds that.
    assign pick_ptr = (state_q == ARB_GRANT) ? next_ptr : ptr_q;

    rr_pick #(
        .N   (N),
        .IdW (IdW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    gnt_d   = N'(1) << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = HoldW'(1);
                end
            end
            ARB_GRANT: begin
                if (tenure_end) begin
                    ptr_d     = next_ptr;
                    // A release by drop takes precedence over a coincident expiry.
                    preempt_d = owner_req && expired;
                    if (pick_found) begin
                        gnt_d   = N'(1) << pick_idx;
                        owner_d = pick_idx;
                        hold_d  = HoldW'(1);
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q != {HoldW{1'b1}}) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = owner_q;
    assign preempt   = preempt_q;

`ifdef RR_ARB_SVA_EN
    localparam int unsigned FairBound = (N - 1) * MAX_HOLD + 1;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid:  assert property (@(posedge clk) disable iff (rst) gnt_valid == |gnt);

    if (MAX_HOLD == 0) begin : g_no_preempt
        a_no_preempt: assert property (@(posedge clk) disable iff (rst) !preempt);
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_req_sva
        a_gnt_req: assert property (@(posedge clk) disable iff (rst)
            gnt[i] |-> $past(req[i]));
        if (MAX_HOLD != 0) begin : g_fair
            a_fair: assert property (@(posedge clk) disable iff (rst)
                req[i] && !gnt[i] |-> ##[1:FairBound] (gnt[i] || !req[i]));
        end
        // Covers expose any path a bench never reaches instead of a vacuous pass.
        c_grant:   cover property (@(posedge clk) disable iff (rst) $rose(gnt[i]));
        c_drop:    cover property (@(posedge clk) disable iff (rst)
            gnt[i] && !req[i] ##1 !gnt[i]);
        c_preempt: cover property (@(posedge clk) disable iff (rst)
            $past(gnt[i]) && preempt);
        c_handoff: cover property (@(posedge clk) disable iff (rst)
            gnt[i] ##1 (gnt_valid && !gnt[i]));
    end
`endif

endmodule

// File: doc/rr_req_gnt_arbiter.md
Name: rr_req_gnt_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters over a per-requester req/gnt handshake.
- A grant is held while the owner keeps req high, up to a MAX_HOLD-cycle tenure limit, then forcibly preempted.
- Sits between requester agents and the shared resource; it is the sequencing block for the req/gnt protocol that the SVA lessons check.
- Assertion and cover set compiles in optionally, so benches can detect vacuous passes.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; 0 = unlimited (no preemption).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level, held until served or abandoned.
- gnt  output  N  registered one-hot-or-zero grant.
- gnt_valid  output  1  OR of gnt.
- gnt_id  output  $clog2(N)  index of current owner; 0 when gnt_valid=0.
- preempt  output  1  one-cycle pulse in the cycle a tenure ends by MAX_HOLD expiry.

Behaviour:
- Reset (rst sampled high): gnt=0, gnt_valid=0, gnt_id=0, preempt=0, ptr=0, hold_cnt=0, state IDLE.
- Reset mid-grant: gnt drops at the same edge that samples rst.
- States: IDLE, GRANT.
- IDLE: if req!=0, winner = first set req bit at or after ptr (circular). Next edge: gnt[winner]=1, state GRANT, hold_cnt=1.
  - Latency: req sampled at edge k -> gnt visible after edge k+1.
- GRANT, owner o: tenure ends when req[o]==0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - Otherwise gnt holds and hold_cnt increments (saturates when MAX_HOLD=0).
- At tenure end: ptr <= (o+1) mod N.
  - Next winner searched from o+1 over current req, excluding o only if req[o]==0.
  - If a winner exists, gnt moves directly to it at the next edge (no bubble) and hold_cnt=1.
  - Otherwise gnt=0 and state IDLE.
- Preempted owner still requesting: it rejoins the rotation. If it is the sole requester, it is regranted immediately with hold_cnt=1 (gnt stays high, preempt still pulses).
- preempt is asserted in the cycle after the edge where expiry was detected, concurrent with the new grant.
- Requester dropping req while not granted: no effect. Requests arriving during GRANT wait; no mid-tenure priority change.
- Fairness bound (MAX_HOLD!=0): a requester holding req high is granted within (N-1)*MAX_HOLD+1 cycles.
- gnt is never high for a requester whose req was low at the deciding edge.

Optional Feature:
- Macro RR_ARB_SVA_EN.
- Defined, compiles in concurrent assertions:
  - $onehot0(gnt).
  - gnt[i] implies $past(req[i]).
  - gnt_valid == |gnt.
  - preempt only when MAX_HOLD!=0.
  - Fairness: req[i] && !gnt[i] |-> ##[1:(N-1)*MAX_HOLD+1] gnt[i], unless req[i] is dropped.
- Defined, also compiles in cover properties per requester: grant, release by drop, preemption, back-to-back handoff.
  - Covers are required so a bench that never exercises a path is visible, not a silent vacuous pass.
- Undefined: no assertion or cover code; RTL behaviour identical.

Decomposition:
- Package arb_pkg: state enum arb_state_e {ARB_IDLE, ARB_GRANT}.
- Package arb_pkg: function rr_next(req, ptr) returning the winner index (parameter-agnostic via max width 16).
- One sub-module, rr_pick: combinational rotating priority encoder (req, ptr -> idx, found), reused by other arbiters.

Test Plan:
- Reset, req=0 for 10 cycles -> gnt=0, gnt_valid=0, preempt=0 throughout; covers show no grant (vacuity visible).
- req=4'b0001 at cycle 2, dropped at cycle 5 -> gnt=0001 from cycle 3 through 5, gnt=0 at cycle 6, ptr=1.
- req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0 with 8 cycles each; preempt pulses at each handoff; gnt never two-hot.
- req=4'b0100 held alone, MAX_HOLD=8 -> gnt stays 0100 continuously, preempt every 8 cycles, gnt_id=2.
- Owner 1 drops req while req[3] is high -> gnt moves 0010 -> 1000 on the next edge, no idle cycle.
- rst=1 during GRANT of requester 2 -> gnt=0 at that edge; after release, req=1111 grants requester 0 first.
